btn_click_decoder: RTL

- Consumer-side counterpart of the button debouncer. It takes the debouncer's single-cycle rising-edge pulse and its debounced held level, and classifies each press as a single click, a double click or a long press.
- Each class is reported as a one-clock pulse to the stopwatch/watch control FSMs.
- The block keeps its own 1 ms time base, made by a clock-divider tick.

---
 rtl/btn_click_decoder.sv | 95 +++++++++
 1 files changed

// File: rtl/btn_click_decoder.sv
// btn_click_decoder: classifies debounced presses into single, double and long clicks on a private 1 ms tick.
// Optional build macro AUTO_REPEAT_EN makes o_long repeat every REPEAT_MS ticks while held.
module btn_click_decoder #(
    parameter int F_COUNT   = 100000,
    parameter int LONG_MS   = 800,
    parameter int DOUBLE_MS = 300,
    parameter int REPEAT_MS = 200
) (
    input  logic clk,
    input  logic rst,
    input  logic i_pulse,
    input  logic i_level,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_busy
);
    localparam int MAX_LD = LONG_MS > DOUBLE_MS ? LONG_MS : DOUBLE_MS;
    localparam int MAX_MS = MAX_LD > REPEAT_MS ? MAX_LD : REPEAT_MS;
    localparam int MW     = $clog2(MAX_MS) + 1;
    localparam int DW     = F_COUNT > 1 ? $clog2(F_COUNT) : 1;

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] PRESSED   = 3'd1;
    localparam logic [2:0] WAIT_2ND  = 3'd2;
    localparam logic [2:0] SECOND    = 3'd3;
    localparam logic [2:0] LONG_HELD = 3'd4;

    logic [DW-1:0] div;
    logic [MW-1:0] ms;
    logic [2:0]    state, nxt;
    logic          tick, timed, restart, fire_s, fire_d, fire_l;

    assign tick   = div == DW'(F_COUNT - 1);
    assign timed  = state == PRESSED || state == WAIT_2ND || state == LONG_HELD;
    assign o_busy = state != IDLE;

    always_ff @(posedge clk or posedge rst)
        if (rst) div <= '0;
        else     div <= tick ? '0 : div + 1'b1;

    // Release and pulse are tested before the tick so they win simultaneous events.
    always_comb begin
        nxt     = state;
        fire_s  = 1'b0;
        fire_d  = 1'b0;
        fire_l  = 1'b0;
        restart = 1'b0;
        case (state)
            IDLE:     if (i_pulse) nxt = PRESSED;
            PRESSED:
                if (!i_level) nxt = WAIT_2ND;
                else if (tick && ms == MW'(LONG_MS - 1)) begin
                    nxt    = LONG_HELD;
                    fire_l = 1'b1;
                end
            WAIT_2ND:
                if (i_pulse) nxt = SECOND;
                else if (tick && ms == MW'(DOUBLE_MS - 1)) begin
                    nxt    = IDLE;
                    fire_s = 1'b1;
                end
            SECOND:
                if (!i_level) begin
                    nxt    = IDLE;
                    fire_d = 1'b1;
                end
            LONG_HELD:
                if (!i_level) nxt = IDLE;
`ifdef AUTO_REPEAT_EN
                else if (tick && ms == MW'(REPEAT_MS - 1)) begin
                    fire_l  = 1'b1;
                    restart = 1'b1;
                end
`endif
            default:  nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= IDLE;
            ms       <= '0;
            o_single <= 1'b0;
            o_double <= 1'b0;
            o_long   <= 1'b0;
        end else begin
            state    <= nxt;
            o_single <= fire_s;
            o_double <= fire_d;
            o_long   <= fire_l;
            if (nxt != state || restart) ms <= '0;
            else if (timed && tick && ms != '1) ms <= ms + 1'b1;
        end
endmodule
